alu_exec_unit: RTL

- Execution-side consumer of the 3-bit ALU operation code produced by the ALU-control decoder.
- Accepts one operation (alu_op, a, b) per valid/ready handshake and computes a registered result with zero/overflow flags.
- Presents the result on a valid/ready output handshake to the register-writeback/branch logic of the multi-cycle CPU datapath.
- Optional iterative multiplier occupies the spare opcode.

---
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if
//   Groups the request and response handshakes of the ALU execution unit.
//   A requester uses the master modport and the unit uses the slave modport.
//
//   Request side : in_valid, in_ready, alu_op[2:0], a[W-1:0], b[W-1:0]
//   Response side: out_valid, out_ready, result[W-1:0], zero, overflow
//   Status       : busy (an operation is in flight)
interface alu_exec_unit_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, busy
  );

  modport slave (
    input  in_valid, alu_op, a, b, out_ready,
    output in_ready, out_valid, result, zero, overflow, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execution-side consumer of the 3-bit ALU operation code. One operation
//   (alu_op, a, b) is accepted per request handshake; the result and its
//   zero/overflow flags are registered and offered on a response handshake.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - alu_exec_unit_if.slave (request/response handshakes + busy)
//
//   Opcodes: 000 ADD, 100 SUB, 001 AND, 101 OR, 010 XOR, 110 SLT, 011 NOR,
//            111 MUL (optional) or constant zero.
//
//   Optional feature macro: ALU_EXEC_MUL_EN
//     Defined   - opcode 111 is an unsigned shift-add multiply (low W bits),
//                 one multiplier bit per cycle, W cycles.
//     Undefined - opcode 111 returns 0 with single-cycle latency and no
//                 multiplier hardware exists.
module alu_exec_unit #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1
`ifdef ALU_EXEC_MUL_EN
    ,
    MUL  = 2'd2
`endif
  } state_t;

  state_t       state;
  logic [W-1:0] result_q;
  logic         zero_q;
  logic         overflow_q;
  logic         out_valid_q;
  logic         busy_q;

  logic         accept;
  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] alu_res;
  logic         alu_ovf;

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = $clog2(W);
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [CW-1:0] cnt;

  // Partial product after folding in the current multiplier LSB.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  // A response being drained frees the unit on the same edge, which is what
  // gives single-cycle ops back-to-back throughput.
  assign bus.in_ready = (state == IDLE) || ((state == RESP) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Single-cycle datapath; feeds only the result register, never the outputs.
  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_op)
      3'b000: begin
        alu_res = sum;
        alu_ovf = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      3'b100: begin
        alu_res = diff;
        alu_ovf = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      3'b001:  alu_res = bus.a & bus.b;
      3'b101:  alu_res = bus.a | bus.b;
      3'b010:  alu_res = bus.a ^ bus.b;
      3'b011:  alu_res = ~(bus.a | bus.b);
      3'b110:  alu_res = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered result, flags, out_valid and busy. A new
  // accept takes priority over returning to IDLE so RESP can chain directly
  // into the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
`endif
    end else begin
      if (accept) begin
`ifdef ALU_EXEC_MUL_EN
        if (bus.alu_op == 3'b111) begin
          state       <= MUL;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b1;
          mcand       <= bus.a;
          mplier      <= bus.b;
          acc         <= '0;
          cnt         <= '0;
        end else
`endif
        begin
          state       <= RESP;
          result_q    <= alu_res;
          zero_q      <= (alu_res == '0);
          overflow_q  <= alu_ovf;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
        end
      end else if ((state == RESP) && bus.out_ready) begin
        state       <= IDLE;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end
`ifdef ALU_EXEC_MUL_EN
      else if (state == MUL) begin
        // One multiplier bit per cycle; the last step writes the result.
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          state       <= RESP;
          result_q    <= acc_next;
          zero_q      <= (acc_next == '0);
          overflow_q  <= 1'b0;
          out_valid_q <= 1'b1;
        end
      end
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;

endmodule
